// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered, handshaked ALU for the multi-cycle CPU datapath. Keeps the lab
// ALU's 4-bit control encoding and zero/cout/overflow flags, and adds logical
// and arithmetic shifts plus an iterative (one step per cycle) unsigned
// shift-add multiplier.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   in_valid     operands/control valid
//   in_ready     block can accept an operation this cycle
//   src1         operand A
//   src2         operand B (shift amount = src2[SHW-1:0])
//   ALU_control  operation select
//   out_valid    result register holds an unconsumed result
//   out_ready    consumer takes the result this cycle
//   result       registered result
//   zero         registered, result == 0
//   cout         registered carry out of the MSB (ADD/SUB only)
//   overflow     registered signed overflow (ADD/SUB), high-half != 0 (MUL)
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t             state_q;
   logic [SHW-1:0]     cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left one place per step
   logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right one place per step
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               cout_q;
   logic               ovf_q;
   logic               out_valid_q;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic accept;
   logic consume;
   logic is_mul_op;

   assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid_q && out_ready;
   assign is_mul_op = (ALU_control == OP_MUL);

   // ---------------------------------------------------------------------------
   // Single-cycle datapath (operates directly on the inputs at accept time)
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]          add_full;
   logic [WIDTH:0]          sub_full;
   logic                    add_cin_msb;
   logic                    sub_cin_msb;
   logic                    add_ovf;
   logic                    sub_ovf;
   logic [SHW-1:0]          shamt;
   logic signed [WIDTH-1:0] sra_res;
   logic [WIDTH-1:0]        alu_res_d;
   logic                    alu_cout_d;
   logic                    alu_ovf_d;

   assign add_full = {1'b0, src1} + {1'b0, src2};
   assign sub_full = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};

   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
   assign add_cin_msb = add_full[WIDTH-1] ^ src1[WIDTH-1] ^ src2[WIDTH-1];
   assign sub_cin_msb = sub_full[WIDTH-1] ^ src1[WIDTH-1] ^ ~src2[WIDTH-1];
   assign add_ovf     = add_cin_msb ^ add_full[WIDTH];
   assign sub_ovf     = sub_cin_msb ^ sub_full[WIDTH];

   assign shamt   = src2[SHW-1:0];
   assign sra_res = $signed(src1) >>> shamt;

   always_comb begin
      alu_res_d  = '0;
      alu_cout_d = 1'b0;
      alu_ovf_d  = 1'b0;
      case (ALU_control)
         OP_AND:  alu_res_d = src1 & src2;
         OP_OR:   alu_res_d = src1 | src2;
         OP_ADD: begin
            alu_res_d  = add_full[WIDTH-1:0];
            alu_cout_d = add_full[WIDTH];
            alu_ovf_d  = add_ovf;
         end
         OP_SUB: begin
            alu_res_d  = sub_full[WIDTH-1:0];
            alu_cout_d = sub_full[WIDTH];
            alu_ovf_d  = sub_ovf;
         end
         OP_NOR:  alu_res_d = ~(src1 | src2);
         OP_NAND: alu_res_d = ~(src1 & src2);
         // Sign of the difference, corrected when the subtraction overflowed.
         OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
         OP_SLL:  alu_res_d = src1 << shamt;
         OP_SRL:  alu_res_d = src1 >> shamt;
         OP_SRA:  alu_res_d = sra_res;
         default: alu_res_d = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Multiplier step
   // ---------------------------------------------------------------------------
   logic [2*WIDTH-1:0] mul_acc_d;
   logic               mul_last;

   assign mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign mul_last  = (cnt_q == SHW'(WIDTH-1));

   // ---------------------------------------------------------------------------
   // Control FSM and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && !is_mul_op) begin
                  result_q    <= alu_res_d;
                  zero_q      <= (alu_res_d == '0);
                  cout_q      <= alu_cout_d;
                  ovf_q       <= alu_ovf_d;
                  out_valid_q <= 1'b1;
               end else begin
                  if (accept) begin
                     mcand_q  <= {{WIDTH{1'b0}}, src1};
                     mplier_q <= src2;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= ST_MUL;
                  end
                  // A MUL can only be accepted once the result register is
                  // free or being drained, so clearing here is always safe.
                  if (consume) begin
                     out_valid_q <= 1'b0;
                  end
               end
            end

            ST_MUL: begin
               acc_q    <= mul_acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + SHW'(1);
               if (mul_last) begin
                  result_q    <= mul_acc_d[WIDTH-1:0];
                  zero_q      <= (mul_acc_d[WIDTH-1:0] == '0);
                  cout_q      <= 1'b0;
                  ovf_q       <= (mul_acc_d[2*WIDTH-1:WIDTH] != '0);
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (consume) begin
                  out_valid_q <= 1'b0;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WIDTH = 32). Inputs change 1 ns after a
// rising edge; a negative-edge monitor pushes the expected outcome of every
// accepted operation into a queue and pops/compares on every consumed result.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 32;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [3:0] OP_BAD  = 4'b1111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] src1 = '0;
   logic [W-1:0] src2 = '0;
   logic [3:0]   ALU_control = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         zero;
   logic         cout;
   logic         overflow;

   alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .src1        (src1),
      .src2        (src2),
      .ALU_control (ALU_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .cout        (cout),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   exp_t sb_q[$];

   // Reference model, written from the opcode table.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t            e;
      logic [W:0]      s;
      logic [63:0]     p;
      logic [4:0]      sh;
      logic signed [W-1:0] sa;
      e    = '0;
      e.op = op;
      sh   = b[4:0];
      case (op)
         OP_AND:  e.res = a & b;
         OP_OR:   e.res = a | b;
         OP_NOR:  e.res = ~(a | b);
         OP_NAND: e.res = ~(a & b);
         OP_ADD: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
         end
         OP_SUB: begin
            s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
         end
         OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLL:  e.res = a << sh;
         OP_SRL:  e.res = a >> sh;
         OP_SRA: begin
            sa    = $signed(a) >>> sh;
            e.res = sa;
         end
         OP_MUL: begin
            p     = {32'd0, a} * {32'd0, b};
            e.res = p[31:0];
            e.v   = (p[63:32] != 32'd0);
         end
         default: e.res = '0;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Scoreboard monitor: consume before accept, so FIFO order is preserved
   // when both happen at the same edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
               e = sb_q.pop_front();
               $display("txn op=%b result=0x%08h cout=%0b ovf=%0b zero=%0b", e.op, result, cout, overflow, zero);
               check_val("sb_result",   64'(result),   64'(e.res));
               check_val("sb_cout",     64'(cout),     64'(e.c));
               check_val("sb_overflow", 64'(overflow), 64'(e.v));
               check_val("sb_zero",     64'(zero),     64'(e.z));
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(ALU_control, src1, src2));
         end
      end
   end

   // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n           = 0;
      in_valid    = 1'b1;
      ALU_control = op;
      src1        = a;
      src2        = b;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check_val("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   vec_t vecs[$] = '{
      '{OP_SUB,  32'h0000_0005, 32'h0000_0005},
      '{OP_SLT,  32'h8000_0000, 32'h0000_0001},
      '{OP_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF},
      '{OP_SRA,  32'h8000_0000, 32'h0000_0004},
      '{OP_SRL,  32'h8000_0000, 32'h0000_0004},
      '{OP_SLL,  32'h0000_0001, 32'h0000_0021},
      '{OP_BAD,  32'h1234_5678, 32'h9ABC_DEF0},
      '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00},
      '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000},
      '{OP_NOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F},
      '{OP_NAND, 32'hFFFF_FFFF, 32'h0000_FFFF},
      '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001},
      '{OP_SUB,  32'h0000_0003, 32'h0000_0005},
      '{OP_SUB,  32'h8000_0000, 32'h0000_0001},
      '{OP_MUL,  32'd123,       32'd456}
   };

   logic [3:0] rand_ops[12] = '{OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SRA,
                                OP_SUB, OP_SLT, OP_MUL, OP_NOR, OP_NAND, 4'b1010};

   initial begin
      int  n;
      bit  ready_low;

      // Reset values
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_in_ready",  64'(in_ready),  64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_result",    64'(result),    64'd0);
      check_val("rst_zero",      64'(zero),      64'd0);
      check_val("rst_cout",      64'(cout),      64'd0);
      check_val("rst_overflow",  64'(overflow),  64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rel_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // ADD overflow case with single-cycle latency
      send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      check_val("add_lat_valid", 64'(out_valid), 64'd1);
      check_val("add_result",    64'(result),    64'h8000_0000);
      @(posedge clk);
      #1;

      // Back-to-back directed vectors
      foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b);

      // Random operations
      for (int i = 0; i < 16; i++) begin
         send(rand_ops[$urandom_range(0, 11)], $urandom, $urandom);
      end

      // MUL latency and in_ready while busy
      send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
      n         = 0;
      ready_low = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (!out_valid && in_ready) ready_low = 1'b0;
      end while (!out_valid && n < 100);
      check_val("mul_latency",      64'(n - 1),    64'(W));
      check_val("mul_in_ready_low", 64'(ready_low), 64'd1);
      check_val("mul_zero",         64'(zero),      64'd1);
      check_val("mul_overflow",     64'(overflow),  64'd1);
      @(posedge clk);
      #1;

      // Backpressure: ADD held, AND waits, then both move on one edge
      out_ready = 1'b0;
      send(OP_ADD, 32'd100, 32'd23);
      in_valid    = 1'b1;
      ALU_control = OP_AND;
      src1        = 32'h0000_F0F0;
      src2        = 32'h0000_FF00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("bp_in_ready", 64'(in_ready),  64'd0);
         check_val("bp_valid",    64'(out_valid), 64'd1);
         check_val("bp_hold",     64'(result),    64'd123);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check_val("bp_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_val("bp_and_valid",  64'(out_valid), 64'd1);
      check_val("bp_and_result", 64'(result),    64'h0000_F000);
      @(posedge clk);
      #1;

      // Reset during the 10th cycle of a MUL
      send(OP_MUL, 32'd7, 32'd9);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_val("mrst_out_valid", 64'(out_valid), 64'd0);
      check_val("mrst_result",    64'(result),    64'd0);
      check_val("mrst_zero",      64'(zero),      64'd0);
      check_val("mrst_cout",      64'(cout),      64'd0);
      check_val("mrst_overflow",  64'(overflow),  64'd0);
      check_val("mrst_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("mrst_rel_ready", 64'(in_ready),  64'd1);
      check_val("mrst_rel_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      send(OP_ADD, 32'd2, 32'd3);
      @(negedge clk);
      check_val("post_rst_add", 64'(result), 64'd5);
      @(posedge clk);
      #1;

      // Drain the scoreboard
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
